// File: rtl/int_ctrl_pkg.sv
// Shared interrupt-controller definitions: FSM state encodings and
// default vector layout, also used by CP0 and exception logic.
package int_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } ic_state_e;

   localparam logic [31:0] VECTOR_BASE_DEF   = 32'h0000_0100;
   localparam logic [31:0] VECTOR_STRIDE_DEF = 32'h0000_0010;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Reusable by the exception arbiter.
module prio_enc #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         valid_o
);

   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// CPU-side interrupt controller: masks, arbitrates and tracks the
// request / taken / return handshake with the pipeline.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int                NUM_SRC       = 4,
   parameter int                ID_W          = 2,
   parameter logic [NUM_SRC-1:0] MASK_RESET   = '1,
   parameter logic [31:0]       VECTOR_BASE   = VECTOR_BASE_DEF,
   parameter logic [31:0]       VECTOR_STRIDE = VECTOR_STRIDE_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] int_i,
   output logic [NUM_SRC-1:0] int_ack_o,
   input  logic               int_en_i,
   input  logic               mask_we_i,
   input  logic [NUM_SRC-1:0] mask_wdata_i,
   output logic [NUM_SRC-1:0] mask_o,
   output logic               irq_o,
   input  logic               irq_taken_i,
   input  logic               eret_i,
   input  logic [31:0]        epc_i,
   output logic [31:0]        epc_o,
   output logic [ID_W-1:0]    cause_o,
   output logic [31:0]        vector_o,
   output logic               in_service_o
);

   localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

   ic_state_e          state_q;
   logic               irq_q;
   logic               insvc_q;
   logic [NUM_SRC-1:0] ack_q;
   logic [NUM_SRC-1:0] mask_q;
   logic [ID_W-1:0]    cause_q;
   logic [31:0]        epc_q;

   logic [NUM_SRC-1:0] elig;
   logic [ID_W-1:0]    win_idx;
   logic               win_vld;

   assign elig = int_i & mask_q & {NUM_SRC{int_en_i}};

   prio_enc #(
      .N (NUM_SRC),
      .W (ID_W)
   ) u_prio (
      .req_i   (elig),
      .idx_o   (win_idx),
      .valid_o (win_vld)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
         insvc_q <= 1'b0;
         ack_q   <= '0;
         mask_q  <= MASK_RESET;
         cause_q <= '0;
         epc_q   <= '0;
      end else begin
         ack_q <= '0;
         if (mask_we_i)
            mask_q <= mask_wdata_i;
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  cause_q <= win_idx;
                  irq_q   <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               // taken has priority over a same-cycle withdraw
               if (irq_taken_i) begin
                  epc_q   <= epc_i;
                  ack_q   <= ONE << cause_q;
                  irq_q   <= 1'b0;
                  insvc_q <= 1'b1;
                  state_q <= SERVICE;
               end else if (!elig[cause_q]) begin
                  irq_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            SERVICE: begin
               if (eret_i) begin
                  insvc_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               irq_q   <= 1'b0;
               insvc_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign int_ack_o    = ack_q;
   assign mask_o       = mask_q;
   assign irq_o        = irq_q;
   assign epc_o        = epc_q;
   assign cause_o      = cause_q;
   assign in_service_o = insvc_q;
   assign vector_o     = VECTOR_BASE + 32'(cause_q) * VECTOR_STRIDE;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  int_i = '0;
   logic [3:0]  int_ack_o;
   logic        int_en_i = 1'b0;
   logic        mask_we_i = 1'b0;
   logic [3:0]  mask_wdata_i = '0;
   logic [3:0]  mask_o;
   logic        irq_o;
   logic        irq_taken_i = 1'b0;
   logic        eret_i = 1'b0;
   logic [31:0] epc_i = '0;
   logic [31:0] epc_o;
   logic [1:0]  cause_o;
   logic [31:0] vector_o;
   logic        in_service_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   int_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .int_i        (int_i),
      .int_ack_o    (int_ack_o),
      .int_en_i     (int_en_i),
      .mask_we_i    (mask_we_i),
      .mask_wdata_i (mask_wdata_i),
      .mask_o       (mask_o),
      .irq_o        (irq_o),
      .irq_taken_i  (irq_taken_i),
      .eret_i       (eret_i),
      .epc_i        (epc_i),
      .epc_o        (epc_o),
      .cause_o      (cause_o),
      .vector_o     (vector_o),
      .in_service_o (in_service_o)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      tick();
      check("rst_irq", 32'(irq_o), 0);
      check("rst_ack", 32'(int_ack_o), 0);
      check("rst_svc", 32'(in_service_o), 0);
      check("rst_cause", 32'(cause_o), 0);
      check("rst_epc", epc_o, 0);
      check("rst_mask", 32'(mask_o), 32'hf);
      reset = 1'b0;
      int_en_i = 1'b1;

      // ignored taken/eret in IDLE
      irq_taken_i = 1'b1;
      eret_i = 1'b1;
      epc_i = 32'hdead_beef;
      tick();
      irq_taken_i = 1'b0;
      eret_i = 1'b0;
      tick();
      check("ign_irq", 32'(irq_o), 0);
      check("ign_ack", 32'(int_ack_o), 0);
      check("ign_svc", 32'(in_service_o), 0);
      check("ign_epc", epc_o, 0);

      // single request
      int_i = 4'b0001;
      tick();
      check("s_irq", 32'(irq_o), 1);
      check("s_cause", 32'(cause_o), 0);
      check("s_vec", vector_o, 32'h100);
      irq_taken_i = 1'b1;
      epc_i = 32'h40;
      tick();
      irq_taken_i = 1'b0;
      check("s_ack", 32'(int_ack_o), 32'h1);
      check("s_epc", epc_o, 32'h40);
      check("s_svc", 32'(in_service_o), 1);
      check("s_irq_lo", 32'(irq_o), 0);
      int_i = 4'b0000;
      tick();
      check("s_ack_1cyc", 32'(int_ack_o), 0);
      eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      check("s_eret_svc", 32'(in_service_o), 0);
      tick();
      check("s_idle_irq", 32'(irq_o), 0);

      // priority
      int_i = 4'b1010;
      tick();
      check("p_cause", 32'(cause_o), 1);
      check("p_vec", vector_o, 32'h110);
      irq_taken_i = 1'b1;
      epc_i = 32'h80;
      tick();
      irq_taken_i = 1'b0;
      check("p_ack", 32'(int_ack_o), 32'h2);
      int_i = 4'b1000;
      tick();
      eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      check("p_irq_e1", 32'(irq_o), 0);
      tick();
      check("p_irq_e2", 32'(irq_o), 1);
      check("p_cause3", 32'(cause_o), 3);
      check("p_vec3", vector_o, 32'h130);
      irq_taken_i = 1'b1;
      tick();
      irq_taken_i = 1'b0;
      check("p_ack3", 32'(int_ack_o), 32'h8);
      int_i = 4'b0000;
      tick();
      eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      tick();

      // mask blocks source 0
      mask_we_i = 1'b1;
      mask_wdata_i = 4'b1110;
      tick();
      mask_we_i = 1'b0;
      check("m_mask", 32'(mask_o), 32'he);
      int_i = 4'b0001;
      tick();
      tick();
      check("m_irq", 32'(irq_o), 0);
      int_i = 4'b0000;
      mask_we_i = 1'b1;
      mask_wdata_i = 4'b1111;
      tick();
      mask_we_i = 1'b0;

      // withdraw via int_en_i
      int_i = 4'b0100;
      tick();
      check("w_irq", 32'(irq_o), 1);
      check("w_cause", 32'(cause_o), 2);
      int_en_i = 1'b0;
      tick();
      check("w_irq_lo", 32'(irq_o), 0);
      check("w_noack", 32'(int_ack_o), 0);
      tick();
      check("w_noack2", 32'(int_ack_o), 0);
      int_en_i = 1'b1;
      tick();
      check("w_rearb", 32'(irq_o), 1);

      // withdraw and taken together: taken wins
      int_en_i = 1'b0;
      irq_taken_i = 1'b1;
      epc_i = 32'h1234;
      tick();
      irq_taken_i = 1'b0;
      int_en_i = 1'b1;
      check("wt_ack", 32'(int_ack_o), 32'h4);
      check("wt_svc", 32'(in_service_o), 1);
      check("wt_epc", epc_o, 32'h1234);
      int_i = 4'b0000;
      tick();

      // new request during SERVICE is held off
      int_i = 4'b0001;
      tick();
      tick();
      check("sv_irq", 32'(irq_o), 0);
      check("sv_svc", 32'(in_service_o), 1);
      check("sv_cause", 32'(cause_o), 2);
      eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      tick();
      check("sv_irq_after", 32'(irq_o), 1);
      check("sv_cause0", 32'(cause_o), 0);

      // reset during REQ, after a mask write
      mask_we_i = 1'b1;
      mask_wdata_i = 4'b0111;
      tick();
      mask_we_i = 1'b0;
      check("r_mask_wr", 32'(mask_o), 32'h7);
      reset = 1'b1;
      #1;
      check("rr_irq", 32'(irq_o), 0);
      check("rr_cause", 32'(cause_o), 0);
      check("rr_epc", epc_o, 0);
      check("rr_mask", 32'(mask_o), 32'hf);
      tick();
      reset = 1'b0;
      tick();
      check("rr_rearb", 32'(irq_o), 1);

      // reset during SERVICE
      irq_taken_i = 1'b1;
      epc_i = 32'h55;
      tick();
      irq_taken_i = 1'b0;
      check("rs_ack", 32'(int_ack_o), 32'h1);
      check("rs_svc", 32'(in_service_o), 1);
      reset = 1'b1;
      #1;
      check("rs_svc0", 32'(in_service_o), 0);
      check("rs_ack0", 32'(int_ack_o), 0);
      check("rs_epc0", epc_o, 0);
      tick();
      reset = 1'b0;
      tick();
      check("rs_rearb", 32'(irq_o), 1);
      check("rs_noack", 32'(int_ack_o), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- CPU-side interrupt controller; the receiving end of the external interrupt request/acknowledge handshake.
- Collects level-held requests from NUM_SRC sources (source 0 is the debounced board button), applies a per-source mask and a global enable, and selects one request by fixed priority.
- Presents the selected request to the pipeline and tracks the taken/return handshake.
- Returns a one-cycle acknowledge to the winning source when the pipeline takes the interrupt.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8).
- ID_W, 2, width of the source index; must satisfy 2**ID_W >= NUM_SRC.
- MASK_RESET, 4'b1111, per-source mask value loaded on reset (1 = enabled).
- VECTOR_BASE, 32'h0000_0100, handler address for source 0.
- VECTOR_STRIDE, 32'h0000_0010, address spacing between source vectors.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- int_i  in  NUM_SRC  level requests; each source holds its bit until acknowledged
- int_ack_o  out  NUM_SRC  one-cycle acknowledge, one-hot to the serviced source
- int_en_i  in  1  global interrupt enable from the status register
- mask_we_i  in  1  write strobe for the mask register
- mask_wdata_i  in  NUM_SRC  new mask value
- mask_o  out  NUM_SRC  current mask
- irq_o  out  1  interrupt request to the pipeline
- irq_taken_i  in  1  pipeline has flushed and redirected to vector_o
- eret_i  in  1  handler return committed
- epc_i  in  32  PC of the interrupted instruction, valid with irq_taken_i
- epc_o  out  32  latched return PC
- cause_o  out  ID_W  index of the selected or serviced source
- vector_o  out  32  handler address
- in_service_o  out  1  high while the handler is running

Behaviour:
- Reset values:
  - state = IDLE.
  - irq_o, int_ack_o, in_service_o, cause_o, epc_o = 0.
  - mask = MASK_RESET.
  - Reset mid-operation discards any request or service in flight. No ack is issued. A source still holding its request is re-arbitrated after reset.
- Eligibility: elig = int_i & mask & {NUM_SRC{int_en_i}}. The winner is the lowest set index.
- State IDLE:
  - If elig != 0, latch the winner into cause_q and go to REQ. irq_o goes high on the next cycle (registered).
- State REQ:
  - irq_o = 1. cause_o is held stable, with no preemption by newly arriving higher-priority sources.
  - On irq_taken_i: latch epc_i into epc_o, pulse int_ack_o[cause_q] for exactly the next cycle, and go to SERVICE.
  - Withdraw: if elig[cause_q] drops (mask cleared or int_en_i low) and irq_taken_i is low, return to IDLE with irq_o = 0 on the next cycle.
  - If taken and withdraw happen in the same cycle, taken wins.
- State SERVICE:
  - in_service_o = 1, irq_o = 0, no new arbitration (no nesting).
  - On eret_i: go to IDLE. With a request pending, irq_o reasserts at the earliest 2 cycles after eret_i.
- Ignored inputs: irq_taken_i outside REQ and eret_i outside SERVICE are ignored.
- Acknowledge timing: int_ack_o is asserted exactly 1 cycle after irq_taken_i and never for more than one cycle.
  - The source clears its request on (request & ack). The request may still read high in the first SERVICE cycle; this is harmless because arbitration is frozen in SERVICE.
- Mask register:
  - mask_we_i writes the mask in any state; the new mask takes effect the next cycle.
  - A write during SERVICE does not affect the interrupt being serviced.
- Vector: vector_o = VECTOR_BASE + cause_q * VECTOR_STRIDE. Combinational from cause_q, 32-bit, wrap-around ignored.

Decomposition:
- Shared header int_ctrl_defs:
  - state encodings IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2;
  - default VECTOR_BASE and VECTOR_STRIDE, shared with the CP0 and exception logic.
- One sub-module, prio_enc: parameterised fixed-priority encoder (NUM_SRC -> ID_W index plus a valid bit), reusable by the exception arbiter.

Test Plan:
- Single request: int_i = 4'b0001, mask = 1111, int_en = 1 -> irq_o high 1 cycle later with cause_o = 0 and vector_o = 0x100. Then irq_taken_i with epc_i = 0x40 -> int_ack_o = 0001 for one cycle, epc_o = 0x40, in_service_o = 1.
- Priority: int_i = 4'b1010 -> cause_o = 1, vector_o = 0x110. After the ack and source 1 clearing, then eret_i -> cause_o = 3 and irq_o high 2 cycles after eret_i.
- Mask and withdraw:
  - mask = 1110 with int_i = 0001 -> irq_o stays 0.
  - During REQ for source 2, drop int_en_i -> irq_o low next cycle, no ack.
  - Same withdraw with irq_taken_i in the same cycle -> ack to source 2 issued.
- Ignored inputs: irq_taken_i and eret_i pulsed in IDLE -> no state change, outputs stay at reset values. A new request in SERVICE -> irq_o stays 0 until eret_i.
- Reset mid-operation: assert reset during REQ and again during SERVICE -> all outputs 0 immediately and mask = 1111. With the source still held high, irq_o reasserts 1 cycle after reset release.
